pe_brick_mult: RTL and testbench



---
 rtl/pe_pkg.sv | 26 ++
 rtl/pe_brick_cell.sv | 40 ++++
 rtl/pe_brick_mult.sv | 173 +++++++++++++++++
 tb/tb_pe_brick_mult.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg
// Shared constants and helpers for the bit-brick multiplier slice.
// An 8-bit operand is split into BRICK_CNT bricks of BRICK_W bits.
// Each brick pair gives one partial product. Product k (k = BRICK_CNT*i + j)
// is PROD_BASE_W + BRICK_W*(i+j) bits wide, which matches the adder-tree input.
package pe_pkg;

  localparam int BRICK_W     = 2;
  localparam int BRICK_CNT   = 4;
  localparam int PROD_BASE_W = 9;
  localparam int OPND_W      = BRICK_W * BRICK_CNT;
  localparam int PROD_CNT    = BRICK_CNT * BRICK_CNT;

  // Operand pair held in stage 1; the strategy flag travels with its pair
  typedef struct packed {
    logic [OPND_W-1:0] act;
    logic [OPND_W-1:0] wgt;
    logic              strategy_en;
  } operand_pair_t;

  // Width of partial product k, where k = BRICK_CNT*i + j
  function automatic int prod_width(input int k);
    return PROD_BASE_W + BRICK_W * ((k / BRICK_CNT) + (k % BRICK_CNT));
  endfunction

endpackage

// File: rtl/pe_brick_cell.sv
// pe_brick_cell
// Multiplies one activation brick (index I) by one weight brick (index J).
// The result is shifted to its binary weight and sign-extended to the
// adder-tree width for that product.
// Ports:
//   act_brick  in   BRICK_W bits   activation brick I
//   wgt_brick  in   BRICK_W bits   weight brick J
//   prod       out  prod_width(4I+J) bits, signed partial product
module pe_brick_cell
  import pe_pkg::*;
#(
  parameter int I = 0,
  parameter int J = 0
) (
  input  logic [BRICK_W-1:0]                          act_brick,
  input  logic [BRICK_W-1:0]                          wgt_brick,
  output logic signed [prod_width(BRICK_CNT*I+J)-1:0] prod
);

  localparam int W     = prod_width(BRICK_CNT*I + J);
  localparam int SHIFT = BRICK_W * (I + J);
  localparam int RAW_W = 2 * (BRICK_W + 1);

  logic signed [BRICK_W:0]   act_ext;
  logic signed [BRICK_W:0]   wgt_ext;
  logic signed [RAW_W-1:0]   raw;
  logic signed [W-1:0]       raw_ext;

  // Only the most significant brick carries the operand sign; lower bricks
  // are plain magnitudes, so they get a zero sign bit.
  assign act_ext = (I == BRICK_CNT-1) ? {act_brick[BRICK_W-1], act_brick} : {1'b0, act_brick};
  assign wgt_ext = (J == BRICK_CNT-1) ? {wgt_brick[BRICK_W-1], wgt_brick} : {1'b0, wgt_brick};

  assign raw     = act_ext * wgt_ext;
  assign raw_ext = {{(W-RAW_W){raw[RAW_W-1]}}, raw};

  // The output is sized so the shifted value can never overflow
  assign prod    = raw_ext <<< SHIFT;

endmodule

// File: rtl/pe_brick_mult.sv
// pe_brick_mult
// Bit-brick partial-product generator in front of the PE adder tree.
// It accepts one signed 8-bit activation/weight pair per handshake and emits
// 16 shifted brick products. Together those products sum to act * wgt.
// The block has a two-stage valid/ready pipeline: stage 1 holds the operands,
// and stage 2 holds the products.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_valid / o_ready      operand-side handshake
//   i_act, i_wgt           signed 8-bit operands
//   i_strategy_en          flag carried alongside the pair
//   o_valid / i_ready      product-side handshake
//   o_strategy_en          flag aligned with the products
//   o_prod_0..o_prod_15    signed partial products, 9..21 bits
//   o_zero_cnt             saturating count of zero products handed off
//                          (only when PE_BRICK_STATS_EN is defined)
// Optional feature macro: PE_BRICK_STATS_EN
module pe_brick_mult
  import pe_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [OPND_W-1:0]                i_act,
  input  logic [OPND_W-1:0]                i_wgt,
  input  logic                             i_strategy_en,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_strategy_en,
  output logic signed [prod_width(0)-1:0]  o_prod_0,
  output logic signed [prod_width(1)-1:0]  o_prod_1,
  output logic signed [prod_width(2)-1:0]  o_prod_2,
  output logic signed [prod_width(3)-1:0]  o_prod_3,
  output logic signed [prod_width(4)-1:0]  o_prod_4,
  output logic signed [prod_width(5)-1:0]  o_prod_5,
  output logic signed [prod_width(6)-1:0]  o_prod_6,
  output logic signed [prod_width(7)-1:0]  o_prod_7,
  output logic signed [prod_width(8)-1:0]  o_prod_8,
  output logic signed [prod_width(9)-1:0]  o_prod_9,
  output logic signed [prod_width(10)-1:0] o_prod_10,
  output logic signed [prod_width(11)-1:0] o_prod_11,
  output logic signed [prod_width(12)-1:0] o_prod_12,
  output logic signed [prod_width(13)-1:0] o_prod_13,
  output logic signed [prod_width(14)-1:0] o_prod_14,
  output logic signed [prod_width(15)-1:0] o_prod_15
`ifdef PE_BRICK_STATS_EN
  ,
  output logic [15:0]                      o_zero_cnt
`endif
);

  logic          s1_v;
  logic          s2_v;
  logic          s1_load;
  logic          s2_load;
  operand_pair_t s1_q;
  logic          s2_strategy_en;

`ifdef PE_BRICK_STATS_EN
  logic [PROD_CNT-1:0] prod_zero;
`endif

  // Stage 2 takes a new pair when it is empty or being drained this cycle.
  // Stage 1 can accept whenever its content moves on in the same cycle, so
  // back-to-back pairs flow at one per clock.
  assign s2_load = s1_v && (!s2_v || i_ready);
  assign o_ready = !s1_v || s2_load;
  assign s1_load = i_valid && o_ready;

  // Valid bits: a load sets a stage; draining without a refill clears it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s1_load)      s1_v <= 1'b1;
      else if (s2_load) s1_v <= 1'b0;
      if (s2_load)      s2_v <= 1'b1;
      else if (i_ready) s2_v <= 1'b0;
    end
  end

  // Stage 1 operand register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= '0;
    end else if (s1_load) begin
      s1_q <= '{act: i_act, wgt: i_wgt, strategy_en: i_strategy_en};
    end
  end

  // The stage-2 flag is copied from stage 1, so it always belongs to the
  // same pair as the products next to it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_strategy_en <= 1'b0;
    end else if (s2_load) begin
      s2_strategy_en <= s1_q.strategy_en;
    end
  end

  // One cell and one exact-width stage-2 register per brick pair
  for (genvar i = 0; i < BRICK_CNT; i++) begin : g_act
    for (genvar j = 0; j < BRICK_CNT; j++) begin : g_wgt
      localparam int K = BRICK_CNT*i + j;
      logic signed [prod_width(K)-1:0] cell_prod;
      logic signed [prod_width(K)-1:0] prod_q;

      pe_brick_cell #(.I(i), .J(j)) u_cell (
        .act_brick (s1_q.act[BRICK_W*i +: BRICK_W]),
        .wgt_brick (s1_q.wgt[BRICK_W*j +: BRICK_W]),
        .prod      (cell_prod)
      );

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          prod_q <= '0;
        end else if (s2_load) begin
          prod_q <= cell_prod;
        end
      end

`ifdef PE_BRICK_STATS_EN
      assign prod_zero[K] = (prod_q == '0);
`endif
    end
  end

  assign o_valid       = s2_v;
  assign o_strategy_en = s2_strategy_en;
  assign o_prod_0      = g_act[0].g_wgt[0].prod_q;
  assign o_prod_1      = g_act[0].g_wgt[1].prod_q;
  assign o_prod_2      = g_act[0].g_wgt[2].prod_q;
  assign o_prod_3      = g_act[0].g_wgt[3].prod_q;
  assign o_prod_4      = g_act[1].g_wgt[0].prod_q;
  assign o_prod_5      = g_act[1].g_wgt[1].prod_q;
  assign o_prod_6      = g_act[1].g_wgt[2].prod_q;
  assign o_prod_7      = g_act[1].g_wgt[3].prod_q;
  assign o_prod_8      = g_act[2].g_wgt[0].prod_q;
  assign o_prod_9      = g_act[2].g_wgt[1].prod_q;
  assign o_prod_10     = g_act[2].g_wgt[2].prod_q;
  assign o_prod_11     = g_act[2].g_wgt[3].prod_q;
  assign o_prod_12     = g_act[3].g_wgt[0].prod_q;
  assign o_prod_13     = g_act[3].g_wgt[1].prod_q;
  assign o_prod_14     = g_act[3].g_wgt[2].prod_q;
  assign o_prod_15     = g_act[3].g_wgt[3].prod_q;

`ifdef PE_BRICK_STATS_EN
  logic [4:0]  zero_num;
  logic [16:0] zero_sum;

  // Number of zero products currently in stage 2 (0..16)
  always_comb begin
    zero_num = '0;
    for (int k = 0; k < PROD_CNT; k++) begin
      zero_num = zero_num + {4'd0, prod_zero[k]};
    end
  end

  assign zero_sum = {1'b0, o_zero_cnt} + {12'd0, zero_num};

  // Accumulate on each output handshake and stick at all-ones once full
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_zero_cnt <= '0;
    end else if (s2_v && i_ready) begin
      o_zero_cnt <= zero_sum[16] ? 16'hFFFF : zero_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pe_brick_mult.sv
// tb_pe_brick_mult
// Self-checking bench for pe_brick_mult. A negedge monitor scoreboards every
// accepted pair. On each output handshake it compares all 16 products, the
// flag, the product sum and (when PE_BRICK_STATS_EN is defined) the zero
// count against an arithmetic model of brick multiplication.
// Directed steps then cover reset, corner operands, backpressure,
// flag alignment and a long random run.
module tb_pe_brick_mult;

  typedef struct packed {
    logic [7:0] act;
    logic [7:0] wgt;
    logic       strat;
  } pair_t;

  logic               i_clk;
  logic               i_rst;
  logic               i_valid;
  logic               o_ready;
  logic [7:0]         i_act;
  logic [7:0]         i_wgt;
  logic               i_strategy_en;
  logic               o_valid;
  logic               i_ready;
  logic               o_strategy_en;
  logic signed [8:0]  o_prod_0;
  logic signed [10:0] o_prod_1;
  logic signed [12:0] o_prod_2;
  logic signed [14:0] o_prod_3;
  logic signed [10:0] o_prod_4;
  logic signed [12:0] o_prod_5;
  logic signed [14:0] o_prod_6;
  logic signed [16:0] o_prod_7;
  logic signed [12:0] o_prod_8;
  logic signed [14:0] o_prod_9;
  logic signed [16:0] o_prod_10;
  logic signed [18:0] o_prod_11;
  logic signed [14:0] o_prod_12;
  logic signed [16:0] o_prod_13;
  logic signed [18:0] o_prod_14;
  logic signed [20:0] o_prod_15;
`ifdef PE_BRICK_STATS_EN
  logic [15:0]        o_zero_cnt;
  int                 model_zc;
`endif

  int    compares;
  int    fails;
  int    out_count;
  pair_t sb[$];
  logic  obs_flags[$];
  logic signed [31:0] snap[16];

  pe_brick_mult dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_act         (i_act),
    .i_wgt         (i_wgt),
    .i_strategy_en (i_strategy_en),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_strategy_en (o_strategy_en),
    .o_prod_0      (o_prod_0),
    .o_prod_1      (o_prod_1),
    .o_prod_2      (o_prod_2),
    .o_prod_3      (o_prod_3),
    .o_prod_4      (o_prod_4),
    .o_prod_5      (o_prod_5),
    .o_prod_6      (o_prod_6),
    .o_prod_7      (o_prod_7),
    .o_prod_8      (o_prod_8),
    .o_prod_9      (o_prod_9),
    .o_prod_10     (o_prod_10),
    .o_prod_11     (o_prod_11),
    .o_prod_12     (o_prod_12),
    .o_prod_13     (o_prod_13),
    .o_prod_14     (o_prod_14),
    .o_prod_15     (o_prod_15)
`ifdef PE_BRICK_STATS_EN
    ,
    .o_zero_cnt    (o_zero_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Value of brick i of an 8-bit operand; the top brick is two's complement
  function automatic int brick_val(input logic [7:0] x, input int i);
    int v;
    v = (int'(x) >> (2*i)) & 3;
    if (i == 3 && v >= 2) v = v - 4;
    return v;
  endfunction

  function automatic int exp_prod(input logic [7:0] a, input logic [7:0] w, input int k);
    return brick_val(a, k/4) * brick_val(w, k%4) * (1 << (2*(k/4 + k%4)));
  endfunction

  function automatic logic signed [31:0] get_prod(input int k);
    case (k)
      0:  return o_prod_0;
      1:  return o_prod_1;
      2:  return o_prod_2;
      3:  return o_prod_3;
      4:  return o_prod_4;
      5:  return o_prod_5;
      6:  return o_prod_6;
      7:  return o_prod_7;
      8:  return o_prod_8;
      9:  return o_prod_9;
      10: return o_prod_10;
      11: return o_prod_11;
      12: return o_prod_12;
      13: return o_prod_13;
      14: return o_prod_14;
      15: return o_prod_15;
      default: return 'x;
    endcase
  endfunction

  function automatic logic signed [31:0] sum_prods();
    logic signed [31:0] s;
    s = 0;
    for (int k = 0; k < 16; k++) s = s + get_prod(k);
    return s;
  endfunction

  task automatic checkValue(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
    compares++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called by the monitor just before an output handshake edge
  task automatic checkOutput();
    pair_t p;
    int    e;
    int    a;
    int    w;
`ifdef PE_BRICK_STATS_EN
    int    nz;
    nz = 0;
`endif
    if (sb.size() == 0) begin
      checkValue("unexpected_output", o_valid, 0);
    end else begin
      p = sb.pop_front();
      for (int k = 0; k < 16; k++) begin
        e = exp_prod(p.act, p.wgt, k);
`ifdef PE_BRICK_STATS_EN
        if (e == 0) nz++;
`endif
        checkValue($sformatf("prod_%0d", k), get_prod(k), e);
      end
      a = int'($signed(p.act));
      w = int'($signed(p.wgt));
      checkValue("strategy", o_strategy_en, p.strat);
      checkValue("sum", sum_prods(), a * w);
`ifdef PE_BRICK_STATS_EN
      checkValue("zero_cnt", o_zero_cnt, model_zc);
      model_zc = (model_zc + nz > 65535) ? 65535 : model_zc + nz;
`endif
      obs_flags.push_back(o_strategy_en);
      out_count++;
    end
  endtask

  // Scoreboard monitor: inputs are stable at negedge, so handshakes seen here
  // are the ones taken at the next rising edge
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
`ifdef PE_BRICK_STATS_EN
      model_zc = 0;
`endif
    end else begin
      if (o_valid && i_ready) checkOutput();
      if (i_valid && o_ready) sb.push_back('{i_act, i_wgt, i_strategy_en});
    end
  end

  // Present one pair and hold it until accepted (bounded); returns 1ns after
  // the accepting edge with i_valid low
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] w, input logic s);
    int waited;
    waited = 0;
    i_valid = 1'b1;
    i_act = a;
    i_wgt = w;
    i_strategy_en = s;
    @(negedge i_clk);
    while (!o_ready && waited < 200) begin
      @(negedge i_clk);
      waited++;
    end
    checkValue("accept", o_ready, 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    for (int k = 0; k < 16; k++) checkValue($sformatf("%s_prod_%0d", tag, k), get_prod(k), 0);
    checkValue({tag, "_valid"}, o_valid, 0);
    checkValue({tag, "_strategy"}, o_strategy_en, 0);
    checkValue({tag, "_ready"}, o_ready, 1);
`ifdef PE_BRICK_STATS_EN
    checkValue({tag, "_zero_cnt"}, o_zero_cnt, 0);
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_valid) && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkValue(tag, sb.size(), 0);
  endtask

  initial begin
    int sent;
    int cycles;
    int base;
    logic accepted;

    compares = 0;
    fails = 0;
    out_count = 0;
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_act = '0;
    i_wgt = '0;
    i_strategy_en = 1'b0;
    i_ready = 1'b0;
`ifdef PE_BRICK_STATS_EN
    model_zc = 0;
`endif

    // Power-on reset
    #1 i_rst = 1'b1;
    #2 checkReset("reset_init");
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Mixed-sign pair: 127 * -127
    i_ready = 1'b1;
    applyStimulus(8'h7F, 8'h81, 1'b0);
    @(posedge i_clk);
    #1;
    checkValue("mixed_valid", o_valid, 1);
    checkValue("mixed_prod0", o_prod_0, 3);
    checkValue("mixed_prod15", o_prod_15, -8192);
    checkValue("mixed_sum", sum_prods(), -16129);
    @(posedge i_clk);
    #1;
`ifdef PE_BRICK_STATS_EN
    checkValue("mixed_zero_cnt", o_zero_cnt, 8);
`endif

    // Most negative operands: only the top brick pair is non-zero
    applyStimulus(8'h80, 8'h80, 1'b1);
    @(posedge i_clk);
    #1;
    checkValue("corner_valid", o_valid, 1);
    checkValue("corner_prod15", o_prod_15, 16384);
    for (int k = 0; k < 15; k++) checkValue($sformatf("corner_prod_%0d", k), get_prod(k), 0);
    checkValue("corner_sum", sum_prods(), 16384);
    @(posedge i_clk);
    #1;
`ifdef PE_BRICK_STATS_EN
    checkValue("corner_zero_cnt", o_zero_cnt, 23);
`endif

    // Backpressure: i_ready low for three cycles while four pairs stream in
    base = out_count;
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_act = 8'($urandom);
    i_wgt = 8'($urandom);
    @(negedge i_clk);
    checkValue("bp_ready_1", o_ready, 1);
    @(posedge i_clk);
    #1;
    i_act = 8'($urandom);
    i_wgt = 8'($urandom);
    @(negedge i_clk);
    checkValue("bp_ready_2", o_ready, 1);
    @(posedge i_clk);
    #1;
    i_act = 8'($urandom);
    i_wgt = 8'($urandom);
    @(negedge i_clk);
    checkValue("bp_ready_full", o_ready, 0);
    checkValue("bp_valid", o_valid, 1);
    for (int k = 0; k < 16; k++) snap[k] = get_prod(k);
    @(posedge i_clk);
    #1;
    checkValue("bp_valid_hold", o_valid, 1);
    for (int k = 0; k < 16; k++) checkValue($sformatf("bp_hold_%0d", k), get_prod(k), snap[k]);
    i_ready = 1'b1;
    applyStimulus(i_act, i_wgt, 1'b0);
    applyStimulus(8'($urandom), 8'($urandom), 1'b0);
    drain("bp_drain");
    checkValue("bp_count", out_count - base, 4);

    // Strategy flag alignment across back-to-back pairs
    obs_flags.delete();
    applyStimulus(8'($urandom), 8'($urandom), 1'b1);
    applyStimulus(8'($urandom), 8'($urandom), 1'b0);
    applyStimulus(8'($urandom), 8'($urandom), 1'b1);
    drain("flag_drain");
    checkValue("flag_count", obs_flags.size(), 3);
    if (obs_flags.size() == 3) begin
      checkValue("flag_0", obs_flags[0], 1);
      checkValue("flag_1", obs_flags[1], 0);
      checkValue("flag_2", obs_flags[2], 1);
    end

    // Reset with a full pipeline: nothing in flight may survive it
    i_ready = 1'b0;
    applyStimulus(8'($urandom), 8'($urandom), 1'b1);
    applyStimulus(8'($urandom), 8'($urandom), 1'b1);
    @(negedge i_clk);
    checkValue("full_valid", o_valid, 1);
    checkValue("full_ready", o_ready, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    #1 checkReset("reset_mid");
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_ready = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      checkValue("no_stale", o_valid, 0);
    end
    @(posedge i_clk);
    #1;

    // Random traffic with random output backpressure
    sent = 0;
    cycles = 0;
    while (sent < 10000 && cycles < 60000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid && $urandom_range(0, 7) != 0) begin
        i_valid = 1'b1;
        i_act = 8'($urandom);
        i_wgt = 8'($urandom);
        i_strategy_en = 1'($urandom);
      end
      @(negedge i_clk);
      accepted = i_valid && o_ready;
      @(posedge i_clk);
      #1;
      cycles++;
      if (accepted) begin
        sent++;
        i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checkValue("random_sent", sent, 10000);
    drain("random_drain");

    $display("[TB] outputs checked: %0d", out_count);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
